// File: rtl/uart_tx_msg_arbiter_pkg.sv
// uart_tx_msg_arbiter_pkg: shared types and message constants for the UART TX arbiter
package uart_tx_msg_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_RISE} tx_arb_state_t;
    localparam logic [7:0] ECHO = 8'h55;
    localparam logic [3:0] STATUS = 4'hB;
    localparam logic [3:0] GESTURE = 4'hA;
    localparam int REQ_GESTURE = 0;
    localparam int REQ_STATUS = 1;
    localparam int REQ_ECHO = 2;
    localparam int REQ_CONFIG = 3;
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/uart_tx_msg_arbiter_if.sv
// uart_tx_msg_arbiter_if: requester side and uart_tx side of the arbiter
interface uart_tx_msg_arbiter_if
    import uart_tx_msg_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) ();
    localparam int W = idw(N_REQ);
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   req_len;
    logic [8*N_REQ-1:0] req_byte0;
    logic [8*N_REQ-1:0] req_byte1;
    logic [N_REQ-1:0]   ack;
    logic [W-1:0]       grant_id;
    logic               arb_busy;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_busy;
    logic               timeout_err;
    modport master (
        output req, req_len, req_byte0, req_byte1, tx_busy,
        input  ack, grant_id, arb_busy, tx_data, tx_valid, timeout_err
    );
    modport slave (
        input  req, req_len, req_byte0, req_byte1, tx_busy,
        output ack, grant_id, arb_busy, tx_data, tx_valid, timeout_err
    );
endinterface

// File: rtl/uart_tx_msg_arbiter_rr_priority_picker.sv
// uart_tx_msg_arbiter_rr_priority_picker: fixed-priority or round-robin one-hot picker
module uart_tx_msg_arbiter_rr_priority_picker
    import uart_tx_msg_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idw(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         rr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);
    int j;
    // Scan from the lowest search offset last so it overrides any later candidate.
    always_comb begin
        onehot = '0;
        idx = '0;
        any = |req;
        j = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = rr ? (int'(ptr) + i) % N : i;
            if (req[j]) begin
                onehot = '0;
                onehot[j] = 1'b1;
                idx = W'(j);
            end
        end
    end
endmodule

// File: rtl/uart_tx_msg_arbiter.sv
// uart_tx_msg_arbiter: shares one uart_tx between N_REQ 1- or 2-byte message sources
module uart_tx_msg_arbiter
    import uart_tx_msg_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int RR_EN = 0,
    parameter int BUSY_TIMEOUT = 15
) (
    input logic clk,
    input logic rst_n,
    uart_tx_msg_arbiter_if.slave bus
);
    localparam int W = idw(N_REQ);
    tx_arb_state_t    state;
    logic             idx;
    logic             len;
    logic [7:0]       b0;
    logic [7:0]       b1;
    logic [7:0]       tcnt;
    logic [W-1:0]     ptr;
    logic [N_REQ-1:0] ack_q;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] win;
    logic [W-1:0]     win_id;
    logic             any;
    // A requester acked in the previous cycle sits out one IDLE decision.
    assign elig = bus.req & ~ack_q;
    uart_tx_msg_arbiter_rr_priority_picker #(.N(N_REQ), .W(W)) u_pick (
        .req(elig),
        .ptr(ptr),
        .rr(RR_EN != 0),
        .onehot(win),
        .idx(win_id),
        .any(any)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= 1'b0;
            len <= 1'b0;
            b0 <= '0;
            b1 <= '0;
            tcnt <= '0;
            ptr <= '0;
            ack_q <= '0;
            bus.ack <= '0;
            bus.grant_id <= '0;
            bus.arb_busy <= 1'b0;
            bus.tx_data <= '0;
            bus.tx_valid <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.ack <= '0;
            bus.tx_valid <= 1'b0;
            ack_q <= bus.ack;
            case (state)
                IDLE: if (any) begin
                    b0 <= bus.req_byte0[{win_id, 3'b000} +: 8];
                    b1 <= bus.req_byte1[{win_id, 3'b000} +: 8];
                    len <= |(bus.req_len & win);
                    idx <= 1'b0;
                    bus.grant_id <= win_id;
                    bus.arb_busy <= 1'b1;
                    ptr <= (win_id == W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
                    state <= SEND;
                end
                SEND: if (!bus.tx_busy) begin
                    bus.tx_valid <= 1'b1;
                    bus.tx_data <= idx ? b1 : b0;
                    tcnt <= '0;
                    state <= WAIT_RISE;
                    if (idx == len) bus.ack <= N_REQ'(1) << bus.grant_id;
                end
                WAIT_RISE: begin
                    tcnt <= tcnt + 8'd1;
                    if (bus.tx_busy || (tcnt + 8'd1) == 8'(BUSY_TIMEOUT)) begin
                        if (!bus.tx_busy) bus.timeout_err <= 1'b1;
                        if (idx != len) begin
                            idx <= 1'b1;
                            state <= SEND;
                        end else begin
                            bus.arb_busy <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
